instruction_fetch: RTL

Fetch sequencer that owns the program counter and drives the instruction memory's read address. It captures the returned big-endian word into a one-entry fetch register and hands it to decode over a valid/ready handshake. It also handles control-flow redirects from the execute stage and flags illegal fetch addresses. It sits between `instruction_memory` and the decode stage and is the only master of the instruction memory read port.

---
 rtl/instruction_fetch.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch sequencer that owns the program counter and is the only master of the
// instruction memory read port. Each cycle the word returned for the current
// pc is captured into a one-entry fetch register and offered to decode over a
// valid/ready handshake. Redirects from execute flush the entry and move the
// pc. Illegal fetch addresses (misaligned or past the end of memory) raise a
// sticky fault.
//
// Parameters:
//   RESET_PC   pc loaded on reset (must be word-aligned to be legal)
//   MEM_BYTES  instruction memory size in bytes (multiple of 4, >= 4)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   imem_address     byte address to instruction memory (equals pc)
//   imem_instruction combinational read data from instruction memory
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new pc when redirect_valid
//   out_valid        fetch register holds an instruction
//   out_ready        decode accepts the instruction this cycle
//   out_instruction  fetched instruction
//   out_pc           address of out_instruction
//   fault            sticky illegal-fetch flag
//   fault_pc         offending address
//
// Configuration macro:
//   INSTRUCTION_FETCH_WRAP_EN  when defined, sequential fetch past the last
//                              word wraps pc to 0 instead of faulting.
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   typedef enum logic [1:0] {
      START = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instruction_q, out_instruction_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;

   logic        slot_free;
   logic        pc_legal;
   logic        target_legal;
   logic        reset_pc_legal;
   logic [31:0] pc_seq;

   // An address is fetchable only if it is word-aligned and the whole word
   // lies inside the memory.
   function automatic logic is_legal(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && (addr <= LAST_ADDR);
   endfunction

   // Address and handshake helpers shared by the next-state logic. The
   // sequential successor either wraps at the last word or simply advances,
   // in which case the overrun is caught as an illegal pc on the next fetch.
   always_comb begin
      slot_free      = !out_valid_q || out_ready;
      pc_legal       = is_legal(pc_q);
      target_legal   = is_legal(redirect_target);
      reset_pc_legal = is_legal(RESET_PC);
`ifdef INSTRUCTION_FETCH_WRAP_EN
      pc_seq = (pc_q >= LAST_ADDR) ? 32'h0000_0000 : pc_q + 32'd4;
`else
      pc_seq = pc_q + 32'd4;
`endif
   end

   // Next-state logic for the fetch FSM and its registered outputs.
   // START spends one cycle without capturing because memory data is forced
   // to zero while reset is held. Outside START a redirect wins over
   // everything: it flushes the entry (even if decode is taking it this
   // cycle) and moves the pc, landing in RUN or FAULT depending on the
   // target. Without a redirect, RUN captures whenever the slot is free and
   // FAULT only lets an existing entry drain.
   always_comb begin
      state_d           = state_q;
      pc_d              = pc_q;
      out_valid_d       = out_valid_q;
      out_instruction_d = out_instruction_q;
      out_pc_d          = out_pc_q;
      fault_d           = fault_q;
      fault_pc_d        = fault_pc_q;

      case (state_q)
         START: begin
            if (reset_pc_legal) begin
               state_d = RUN;
            end else begin
               state_d    = FAULT;
               fault_d    = 1'b1;
               fault_pc_d = RESET_PC;
            end
         end

         RUN, FAULT: begin
            if (redirect_valid) begin
               pc_d        = redirect_target;
               out_valid_d = 1'b0;
               if (target_legal) begin
                  state_d = RUN;
                  fault_d = 1'b0;
               end else begin
                  state_d    = FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_target;
               end
            end else if (state_q == RUN) begin
               if (slot_free) begin
                  if (pc_legal) begin
                     out_valid_d       = 1'b1;
                     out_instruction_d = imem_instruction;
                     out_pc_d          = pc_q;
                     pc_d              = pc_seq;
                  end else begin
                     out_valid_d = 1'b0;
                     state_d     = FAULT;
                     fault_d     = 1'b1;
                     fault_pc_d  = pc_q;
                  end
               end
            end else begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = START;
         end
      endcase
   end

   // State register. Reset overrides any concurrent redirect or capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= START;
         pc_q              <= RESET_PC;
         out_valid_q       <= 1'b0;
         out_instruction_q <= 32'h0000_0000;
         out_pc_q          <= 32'h0000_0000;
         fault_q           <= 1'b0;
         fault_pc_q        <= 32'h0000_0000;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         out_valid_q       <= out_valid_d;
         out_instruction_q <= out_instruction_d;
         out_pc_q          <= out_pc_d;
         fault_q           <= fault_d;
         fault_pc_q        <= fault_pc_d;
      end
   end

   assign imem_address    = pc_q;
   assign out_valid       = out_valid_q;
   assign out_instruction = out_instruction_q;
   assign out_pc          = out_pc_q;
   assign fault           = fault_q;
   assign fault_pc        = fault_pc_q;

endmodule
